// File: rtl/neuron_accum_ctrl.sv
// Sequencer that time-shares an external signed adder to accumulate a bias plus N_TERMS
// signed terms into one saturated neuron pre-activation value.
module neuron_accum_ctrl #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned IN_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] bias,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic [IN_W-1:0]  add_in1,
    output logic [ACC_W-1:0] add_in2,
    input  logic [ACC_W-1:0] add_sum,
    input  logic             add_carry,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(N_TERMS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N_TERMS - 1);
    localparam logic [ACC_W-1:0] MaxVal = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] MinVal = {1'b1, {(ACC_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StLoad, StAccum, StDone} state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CntW-1:0]  count_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             ovf_q;

    logic             hs;
    logic             sat_hit;
    logic [ACC_W-1:0] sat_val;

    // The 17-bit result overflows ACC_W exactly when the carry disagrees with the sum's sign.
    always_comb begin
        hs      = (state_q == StAccum) && in_valid && in_ready_q;
        sat_hit = (add_carry != add_sum[ACC_W-1]);
        sat_val = add_sum;
        if (sat_hit) begin
            sat_val = add_carry ? MinVal : MaxVal;
        end
    end

    always_comb begin
        add_in1 = (state_q == StAccum) ? in_data : '0;
        add_in2 = acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= bias;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    in_ready_q <= 1'b1;
                    state_q    <= StAccum;
                end
                StAccum: begin
                    if (hs) begin
                        acc_q   <= sat_val;
                        count_q <= count_q + 1'b1;
                        if (sat_hit) begin
                            ovf_q <= 1'b1;
                        end
                        if (count_q == LastCnt) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // acc only moves in ACCUM or on an accepted start, so it is stable for the whole DONE window.
    assign out_data  = acc_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// Bench for neuron_accum_ctrl: models the shared signed adder and checks evaluations from a
// vector table through an expected-result queue, plus reset-abort and hold corner cases.
module tb_neuron_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  add_in1;
    logic [15:0] add_in2;
    logic [15:0] add_sum;
    logic        add_carry;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_cnt = 0;

    always #5 clk = ~clk;

    neuron_accum_ctrl #(
        .N_TERMS(4),
        .ACC_W  (16),
        .IN_W   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .add_in1  (add_in1),
        .add_in2  (add_in2),
        .add_sum  (add_sum),
        .add_carry(add_carry),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy),
        .ovf      (ovf)
    );

    // Signed adder: 8-bit + 16-bit -> 17-bit, split into carry and sum.
    logic [16:0] add_r;
    always_comb begin
        add_r     = {{9{add_in1[7]}}, add_in1} + {add_in2[15], add_in2};
        add_sum   = add_r[15:0];
        add_carry = add_r[16];
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (in_ready) ready_cnt <= ready_cnt + 1;

    typedef struct {
        logic [15:0]      bias;
        logic [3:0][7:0]  terms;
        int               max_gap;
        int               hold;
        bit               start_on_accept;
        logic [15:0]      exp_data;
        bit               exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        bit          ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic feed_term(input logic [7:0] t, input int gap);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = t;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            if (in_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) check("in_ready_timeout", {31'b0, in_ready}, 1);
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int   c0;
        int   r0;
        bit   ok;
        exp_t e;
        start = 1'b1;
        bias  = v.bias;
        c0    = cyc;
        r0    = ready_cnt;
        e.data = v.exp_data;
        e.ovf  = v.exp_ovf;
        sb.push_back(e);
        tick();
        start = 1'b0;
        bias  = 16'($urandom);
        check("busy_after_start", {31'b0, busy}, 1);
        for (int i = 0; i < 4; i++) begin
            feed_term(v.terms[i], (v.max_gap > 0) ? int'($urandom_range(v.max_gap, 0)) : 0);
        end
        in_valid = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            if (out_valid) ok = 1'b1;
            else tick();
        end
        check("out_valid_seen", {31'b0, out_valid}, 1);
        if (v.max_gap == 0) begin
            check("latency", cyc - c0, 6);
            check("in_ready_cycles", ready_cnt - r0, 4);
        end
        check("in_ready_in_done", {31'b0, in_ready}, 0);
        for (int h = 0; h < v.hold; h++) begin
            start = 1'b1;
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_data", {16'b0, out_data}, {16'b0, sb[0].data});
            check("hold_in_ready", {31'b0, in_ready}, 0);
            tick();
        end
        start     = v.start_on_accept;
        out_ready = 1'b1;
        e = sb.pop_front();
        check("out_valid_at_accept", {31'b0, out_valid}, 1);
        check("out_data", {16'b0, out_data}, {16'b0, e.data});
        check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("out_valid_dropped", {31'b0, out_valid}, 0);
        check("busy_idle", {31'b0, busy}, 0);
        check("ovf_sticky", {31'b0, ovf}, {31'b0, e.ovf});
        tick();
        check("start_on_accept_ignored", {31'b0, busy}, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_ovf"}, {31'b0, ovf}, 0);
        check({tag, "_out_data"}, {16'b0, out_data}, 0);
        check({tag, "_add_in1"}, {24'b0, add_in1}, 0);
        check({tag, "_add_in2"}, {16'b0, add_in2}, 0);
    endtask

    initial begin
        vecs[0] = '{16'd0,     {8'd4, 8'd3, 8'd2, 8'd1},       0, 0, 1'b0, 16'd10,    1'b0};
        vecs[1] = '{16'd32760, {8'd1, 8'hFD, 8'd5, 8'd5},      0, 0, 1'b0, 16'd32765, 1'b1};
        vecs[2] = '{16'h8000,  {8'd0, 8'd0, 8'h80, 8'hFF},     0, 0, 1'b0, 16'h8000,  1'b1};
        vecs[3] = '{16'd100,   {8'h88, 8'd20, 8'hF9, 8'd7},    3, 0, 1'b0, 16'd0,     1'b0};
        vecs[4] = '{16'hFFCE,  {8'd40, 8'hE2, 8'd20, 8'd10},   0, 5, 1'b1, 16'hFFF6,  1'b0};
        vecs[5] = '{16'd1,     {8'd1, 8'd1, 8'd1, 8'd1},       0, 0, 1'b0, 16'd5,     1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        bias      = 16'd0;
        in_valid  = 1'b0;
        in_data   = 8'h5A;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Abort after two terms; the saturating bias makes ovf visible before the reset.
        start = 1'b1;
        bias  = 16'd32767;
        tick();
        start = 1'b0;
        feed_term(8'd3, 0);
        feed_term(8'd4, 0);
        check("ovf_before_abort", {31'b0, ovf}, 1);
        in_data = 8'd9;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_values("abort");

        run_vec(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
